// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the IFU (read-only) and the LSU.
// Define MEM_ARB_FIXED_PRIO_EN to make the LSU win every simultaneous request.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_wen,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} side_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    side_t       last_grant, owner;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [3:0]  wstrb_q;
    logic [31:0] ifu_rdata_q, lsu_rdata_q;

    logic grant_ifu, grant_lsu;
    logic ifu_hs, lsu_hs, final_access, resp_hs;

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant_lsu = 1'b1;
`else
            if (last_grant == OWN_LSU) grant_ifu = 1'b1;
            else                       grant_lsu = 1'b1;
`endif
        end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
        end
    end

    assign ifu_hs       = ifu_req_valid & ifu_req_ready;
    assign lsu_hs       = lsu_req_valid & lsu_req_ready;
    assign final_access = (state == ACCESS) && (cnt == '0);
    assign resp_hs      = (state == RESP) &&
                          ((owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ifu_hs || lsu_hs) state_next = ACCESS;
            ACCESS:  if (cnt == '0)        state_next = RESP;
            RESP:    if (resp_hs)          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ram_wen        = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
            end
            ACCESS:  ram_wen = wen_q & (cnt == '0);
            RESP: begin
                ifu_resp_valid = (owner == OWN_IFU);
                lsu_resp_valid = (owner == OWN_LSU);
            end
            default: ;
        endcase
    end

    // Request latches, wait counter and response data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= OWN_LSU;
            owner       <= OWN_IFU;
            cnt         <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            if (lsu_hs) begin
                owner      <= OWN_LSU;
                last_grant <= OWN_LSU;
                cnt        <= WAIT_INIT;
                addr_q     <= lsu_addr;
                wen_q      <= lsu_wen;
                wdata_q    <= lsu_wdata;
                wstrb_q    <= lsu_wstrb;
            end else if (ifu_hs) begin
                owner      <= OWN_IFU;
                last_grant <= OWN_IFU;
                cnt        <= WAIT_INIT;
                addr_q     <= ifu_addr;
                wen_q      <= 1'b0;
                wdata_q    <= '0;
                wstrb_q    <= '0;
            end
            if (state == ACCESS && cnt != '0) cnt <= cnt - 4'd1;
            // RAM read is combinational, so this captures pre-write data on stores
            if (final_access) begin
                if (owner == OWN_IFU) ifu_rdata_q <= ram_rdata;
                else                  lsu_rdata_q <= ram_rdata;
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_wstrb = wstrb_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural byte-strobed RAM model.
module tb_mem_arbiter;

    localparam int unsigned W = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wen;
    logic [3:0]  ram_wstrb;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wen_cycles = 0;

    logic [31:0] mem [0:255] = '{0: 32'h0000_0413, 64: 32'h1234_5678,
                                 65: 32'hCAFE_F00D, default: 32'h0};

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (ram_wen) begin
            wen_cycles <= wen_cycles + 1;
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from request to response handshake
    task automatic xact(input string tag, input logic is_lsu, input logic [31:0] addr,
                        input logic wen, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp, input int hold);
        int lat;
        int wen0;
        logic [31:0] other_q;
        other_q = is_lsu ? ifu_rdata : lsu_rdata;
        wen0 = wen_cycles;
        if (is_lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen;
            lsu_wdata = wdata; lsu_wstrb = wstrb;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        #1;
        check({tag, "_ready"}, is_lsu ? lsu_req_ready : ifu_req_ready, 32'd1);
        check({tag, "_other_ready"}, is_lsu ? ifu_req_ready : lsu_req_ready, 32'd0);
        step();
        // Scramble payload: the DUT must use only what it latched at the handshake
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_addr = 32'hFFFF_FFFC; lsu_addr = 32'hFFFF_FFFC;
        lsu_wdata = 32'h0; lsu_wstrb = 4'h0; lsu_wen = 1'b0;
        #1;
        lat = 1;
        while (!(is_lsu ? lsu_resp_valid : ifu_resp_valid) && lat < int'(W) + 10) begin
            check({tag, "_ram_addr"}, ram_addr, addr);
            check({tag, "_ram_wen"}, ram_wen, 32'(wen && lat == int'(W) + 1));
            if (wen && lat == int'(W) + 1) begin
                check({tag, "_ram_wdata"}, ram_wdata, wdata);
                check({tag, "_ram_wstrb"}, ram_wstrb, wstrb);
            end
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, W + 2);
        check({tag, "_rdata"}, is_lsu ? lsu_rdata : ifu_rdata, exp);
        check({tag, "_other_resp_valid"}, is_lsu ? ifu_resp_valid : lsu_resp_valid, 32'd0);
        check({tag, "_other_rdata"}, is_lsu ? ifu_rdata : lsu_rdata, other_q);
        for (int i = 0; i < hold; i++) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            #1;
            check({tag, "_bp_ifu_ready"}, ifu_req_ready, 32'd0);
            check({tag, "_bp_lsu_ready"}, lsu_req_ready, 32'd0);
            step();
            check({tag, "_bp_valid"}, is_lsu ? lsu_resp_valid : ifu_resp_valid, 32'd1);
            check({tag, "_bp_rdata"}, is_lsu ? lsu_rdata : ifu_rdata, exp);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        if (is_lsu) lsu_resp_ready = 1'b1;
        else        ifu_resp_ready = 1'b1;
        step();
        lsu_resp_ready = 1'b0; ifu_resp_ready = 1'b0;
        check({tag, "_resp_done"}, is_lsu ? lsu_resp_valid : ifu_resp_valid, 32'd0);
        check({tag, "_wen_count"}, wen_cycles - wen0, 32'(wen));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        logic exp_lsu;
        int cyc;
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0; ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wstrb = '0; lsu_resp_ready = 1'b0;
        repeat (2) step();

        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wen", ram_wen, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_ram_wstrb", ram_wstrb, 32'h0);
        check("rst_ifu_resp_valid", ifu_resp_valid, 32'h0);
        check("rst_lsu_resp_valid", lsu_resp_valid, 32'h0);
        check("rst_ifu_rdata", ifu_rdata, 32'h0);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);
        reset = 1'b0;
        step();

        // Both requesters valid every cycle with responses always accepted
        ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_0100;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_lsu = 1'b1;
`else
            exp_lsu = (g % 2 == 1);
`endif
            check("rr_lsu_ready", lsu_req_ready, 32'(exp_lsu));
            check("rr_ifu_ready", ifu_req_ready, 32'(!exp_lsu));
            step();
            cyc = 1;
            while (!(ifu_req_ready || lsu_req_ready) && cyc < int'(W) + 10) begin
                step();
                cyc++;
            end
            check("rr_spacing", cyc, W + 3);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        step();

        xact("ifu_fetch", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0);
        xact("lsu_store", 1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678, 0);
        xact("lsu_load_bp", 1'b1, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h1234_BEEF, 5);
        xact("ifu_fetch2", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 2);

        // Reset in the middle of a store's ACCESS phase
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0104; lsu_wen = 1'b1;
        lsu_wdata = 32'h1111_1111; lsu_wstrb = 4'hF;
        #1;
        check("rstmid_ready", lsu_req_ready, 32'd1);
        step();
        lsu_req_valid = 1'b0;
        step();
        check("rstmid_in_access", ram_addr, 32'h8000_0104);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_ram_addr", ram_addr, 32'h0);
        check("rstmid_ram_wen", ram_wen, 32'h0);
        check("rstmid_ram_wdata", ram_wdata, 32'h0);
        check("rstmid_ram_wstrb", ram_wstrb, 32'h0);
        check("rstmid_lsu_rdata", lsu_rdata, 32'h0);
        check("rstmid_ifu_rdata", ifu_rdata, 32'h0);
        check("rstmid_lsu_resp_valid", lsu_resp_valid, 32'h0);
        repeat (3) step();
        #2;
        reset = 1'b0;
        step();
        check("rstmid_wen_count", wen_cycles, 32'd1);
        check("rstmid_ram_word", mem[65], 32'hCAFE_F00D);
        lsu_wen = 1'b0;
        xact("post_rst_load", 1'b1, 32'h8000_0104, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
